module_bus_interconect: RTL

Parametrised, registered bus interconnect between the RISC-V core's data port and up to `N_SLV` memory-mapped peripherals (ROM, RAM, keypad, switches, LEDs, 7-segment, timer, UART, SPI). It decodes the address against a per-slot base/mask table, drives a one-hot select and write-enable to the hit slot, and waits on that slot's acknowledge. It returns registered read data with an `ack_o`/`err_o` response, and flags unmapped addresses and hung slaves as bus errors.

---
 rtl/module_bus_interconect_if.sv | 31 +++
 rtl/module_bus_interconect.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/module_bus_interconect_if.sv
// Bus bundle between the core data port, the interconnect and the peripheral slots.
// master: core + peripherals (drive requests and slot responses); slave: the interconnect.
interface module_bus_interconect_if #(
  parameter int N_SLV = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic                req_i;
  logic                we_i;
  logic [AW-1:0]       addr_i;
  logic [DW-1:0]       wdata_i;
  logic [DW-1:0]       rdata_o;
  logic                ack_o;
  logic                err_o;
  logic [N_SLV-1:0]    sel_o;
  logic [N_SLV-1:0]    we_o;
  logic [AW-1:0]       addr_o;
  logic [DW-1:0]       wdata_o;
  logic [N_SLV*DW-1:0] rdata_i;
  logic [N_SLV-1:0]    ack_i;

  modport master (
    output req_i, we_i, addr_i, wdata_i, rdata_i, ack_i,
    input  rdata_o, ack_o, err_o, sel_o, we_o, addr_o, wdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, rdata_i, ack_i,
    output rdata_o, ack_o, err_o, sel_o, we_o, addr_o, wdata_o
  );
endinterface

// File: rtl/module_bus_interconect.sv
// Registered address-decoding interconnect from the core data port to N_SLV peripheral slots.
// Optional hung-slave timeout is built only when BUS_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for req_i; decodes and latches the request
// S_ACCESS | one-hot select held on the hit slot until its ack (or timeout)
// S_RESP   | ack_o strobe; unmapped requests spend one extra cycle here first
module module_bus_interconect #(
  parameter int                  N_SLV    = 8,
  parameter int                  AW       = 32,
  parameter int                  DW       = 32,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*AW-1:0] SLV_MASK = '0,
  parameter int                  TIMEOUT  = 255
) (
  input logic                     clk_i,
  input logic                     rst_i,
  module_bus_interconect_if.slave bus
);

  if (N_SLV < 1 || N_SLV > 16) begin : g_bad_nslv
    $error("N_SLV must be in 1..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [N_SLV-1:0] r_sel, w_sel_nxt;
  logic [N_SLV-1:0] r_we_o, w_we_o_nxt;
  logic             r_we, w_we_nxt;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic [DW-1:0]    r_wdata, w_wdata_nxt;
  logic [DW-1:0]    r_rdata, w_rdata_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_err, w_err_nxt;
  logic             r_err_pend, w_err_pend_nxt;

  logic             w_hit;
  logic [N_SLV-1:0] w_hit_oh;
  logic             w_slv_ack;
  logic [DW-1:0]    w_slv_rdata;
  logic             w_tmo_hit;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  assign w_tmo_hit = (r_tmo_cnt == CW'(TIMEOUT));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Scan high to low so the lowest matching slot is the one left standing.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_oh = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((bus.addr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        w_hit       = 1'b1;
        w_hit_oh    = '0;
        w_hit_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_slv_ack   = |(bus.ack_i & r_sel);
    w_slv_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (r_sel[i]) w_slv_rdata |= bus.rdata_i[i*DW +: DW];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_we_o_nxt     = r_we_o;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_err_pend_nxt = r_err_pend;
`ifdef BUS_TIMEOUT_EN
    w_tmo_cnt_nxt  = r_tmo_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.req_i) begin
          w_we_nxt    = bus.we_i;
          w_addr_nxt  = bus.addr_i;
          w_wdata_nxt = bus.wdata_i;
          if (w_hit) begin
            w_state_nxt = S_ACCESS;
            w_sel_nxt   = w_hit_oh;
            w_we_o_nxt  = bus.we_i ? w_hit_oh : '0;
`ifdef BUS_TIMEOUT_EN
            w_tmo_cnt_nxt = '0;
`endif
          end else begin
            w_state_nxt    = S_RESP;
            w_err_pend_nxt = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (w_slv_ack) begin
          w_state_nxt = S_RESP;
          w_sel_nxt   = '0;
          w_we_o_nxt  = '0;
          w_rdata_nxt = r_we ? '0 : w_slv_rdata;
          w_ack_nxt   = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_RESP;
          w_sel_nxt   = '0;
          w_we_o_nxt  = '0;
          w_rdata_nxt = '0;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
        end else begin
`ifdef BUS_TIMEOUT_EN
          w_tmo_cnt_nxt = r_tmo_cnt + CW'(1);
`endif
        end
      end
      S_RESP: begin
        // Unmapped requests land here without the strobe; raise it one cycle later.
        if (r_err_pend) begin
          w_err_pend_nxt = 1'b0;
          w_rdata_nxt    = '0;
          w_ack_nxt      = 1'b1;
          w_err_nxt      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_we_o     <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_err_pend <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      r_tmo_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_we_o     <= w_we_o_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_err_pend <= w_err_pend_nxt;
`ifdef BUS_TIMEOUT_EN
      r_tmo_cnt  <= w_tmo_cnt_nxt;
`endif
    end
  end

  assign bus.sel_o   = r_sel;
  assign bus.we_o    = r_we_o;
  assign bus.addr_o  = r_addr;
  assign bus.wdata_o = r_wdata;
  assign bus.rdata_o = r_rdata;
  assign bus.ack_o   = r_ack;
  assign bus.err_o   = r_err;

endmodule
